// File: rtl/digit_serial_subtractor16_pkg.sv
// Shared definitions for the digit-serial subtractor.
// Provides the default operand/digit sizes, the digit count, the counter width helper
// and the control FSM state type.
package digit_serial_subtractor16_pkg;

  localparam int unsigned Width = 16;
  localparam int unsigned Digit = 4;
  localparam int unsigned NDig  = Width / Digit;

  // Counter must be at least one bit wide even for a single-digit configuration.
  function automatic int unsigned cnt_width(input int unsigned n_dig);
    return (n_dig > 1) ? $clog2(n_dig) : 1;
  endfunction

  localparam int unsigned CntW = cnt_width(NDig);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/digit_serial_subtractor16_ripple_borrow_digit.sv
// Combinational DIGIT-bit ripple-borrow subtractor built from full-subtractor cells.
// Ports:
//   a_i      minuend digit
//   b_i      subtrahend digit
//   borrow_i borrow into the least significant cell
//   diff_o   a_i - b_i - borrow_i (mod 2^DIGIT)
//   borrow_o borrow out of the most significant cell
module ripple_borrow_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             borrow_i,
  output logic [DIGIT-1:0] diff_o,
  output logic             borrow_o
);

  logic [DIGIT:0] chain;

  assign chain[0] = borrow_i;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign diff_o[i]    = a_i[i] ^ b_i[i] ^ chain[i];
    // Borrow when a < b, or when a == b and a borrow is already pending.
    assign chain[i+1]   = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & chain[i]);
  end

  assign borrow_o = chain[DIGIT];

endmodule

// File: rtl/digit_serial_subtractor16.sv
// Digit-serial subtractor: result_o = {borrow, min - sub}, one DIGIT-bit digit per clock,
// LSB digit first, borrow carried between digits in a flop.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   valid_i / ready_o    operand handshake (min_i, sub_i)
//   valid_o / ready_i    result handshake (result_o, WIDTH+1 bits, MSB = borrow-out)
module digit_serial_subtractor16
  import digit_serial_subtractor16_pkg::*;
#(
  parameter int unsigned WIDTH = Width,
  parameter int unsigned DIGIT = Digit
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] min_i,
  input  logic [WIDTH-1:0] sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH:0]   result_o
);

  localparam int unsigned NumDig   = WIDTH / DIGIT;
  localparam int unsigned CntWidth = cnt_width(NumDig);
  localparam logic [CntWidth-1:0] LastDig = CntWidth'(NumDig - 1);

  state_e              state_q;
  logic [WIDTH-1:0]    a_q, b_q, acc_q;
  logic                borrow_q;
  logic [CntWidth-1:0] cnt_q;
  logic [WIDTH:0]      result_q;
  logic                ready_q, valid_q;

  logic [DIGIT-1:0]    diff;
  logic                borrow_out;

  // Operands shift right each RUN cycle, so the current digit is always the low digit.
  ripple_borrow_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a_i      (a_q[DIGIT-1:0]),
    .b_i      (b_q[DIGIT-1:0]),
    .borrow_i (borrow_q),
    .diff_o   (diff),
    .borrow_o (borrow_out)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (valid_i) begin
            a_q      <= min_i;
            b_q      <= sub_i;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          a_q      <= a_q >> DIGIT;
          b_q      <= b_q >> DIGIT;
          // Digits enter at the top and drift down; after NumDig shifts they sit in place.
          acc_q    <= {diff, acc_q[WIDTH-1:DIGIT]};
          borrow_q <= borrow_out;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LastDig) begin
            cnt_q    <= '0;
            result_q <= {borrow_out, diff, acc_q[WIDTH-1:DIGIT]};
            valid_q  <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_digit_serial_subtractor16.sv
module tb_digit_serial_subtractor16;

  localparam int unsigned NDIG = 4;

  logic        clk_i;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] min_i;
  logic [15:0] sub_i;
  logic        valid_o;
  logic        ready_i;
  logic [16:0] result_o;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [16:0] sb[$];

  digit_serial_subtractor16 dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .min_i    (min_i),
    .sub_i    (sub_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  // One full operation from IDLE with ready_i high; checks latency and result.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] exp;
    min_i   = a;
    sub_i   = b;
    valid_i = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    min_i   = 16'($urandom);
    sub_i   = 16'($urandom);
    n_checks++;
    if (ready_o !== 1'b0 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL accept: ready_o=%b valid_o=%b, required ready_o=0 valid_o=0", ready_o, valid_o);
    end
    for (int i = 1; i < NDIG; i++) begin
      @(posedge clk_i); #1;
      n_checks++;
      if (valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL early_valid edge %0d: valid_o=%b, required 0", i, valid_o);
      end
    end
    @(posedge clk_i); #1;
    n_checks++;
    if (valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL latency: valid_o=%b after E%0d, required 1", valid_o, NDIG);
    end
    exp = sb.pop_front();
    n_checks++;
    if (result_o !== exp) begin
      n_fail++;
      $display("FAIL result %h-%h: got %h, required %h", a, b, result_o, exp);
    end
    @(posedge clk_i); #1;
    n_checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== exp) begin
      n_fail++;
      $display("FAIL idle_hold: ready_o=%b valid_o=%b result_o=%h, required 1 0 %h",
               ready_o, valid_o, result_o, exp);
    end
  endtask

  task automatic test_reset();
    rst_ni  = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'($urandom);
      min_i   = 16'($urandom);
      sub_i   = 16'($urandom);
      @(negedge clk_i);
      n_checks++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 17'h00000) begin
        n_fail++;
        $display("FAIL reset: valid_o=%b ready_o=%b result_o=%h, required 0 1 00000",
                 valid_o, ready_o, result_o);
      end
    end
    valid_i = 1'b0;
    rst_ni  = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_basic();
    ready_i = 1'b1;
    do_op(16'h7A1B, 16'h29AF);
  endtask

  task automatic test_borrow_wrap();
    logic [15:0] ta[4];
    logic [15:0] tb[4];
    ta = '{16'h1111, 16'h0000, 16'h8943, 16'hABCD};
    tb = '{16'hEEAA, 16'h0001, 16'hFFFF, 16'h0000};
    for (int i = 0; i < 4; i++) do_op(ta[i], tb[i]);
    for (int i = 0; i < 4; i++) do_op(16'($urandom), 16'($urandom));
  endtask

  task automatic test_backpressure();
    logic [16:0] exp;
    ready_i = 1'b0;
    min_i   = 16'h4482;
    sub_i   = 16'h3BCD;
    valid_i = 1'b1;
    sb.push_back(model(16'h4482, 16'h3BCD));
    @(posedge clk_i); #1;
    // Keep offering different operands; they must be ignored in RUN and DONE.
    min_i = 16'hFFFF;
    sub_i = 16'h0001;
    repeat (NDIG) @(posedge clk_i);
    #1;
    exp = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || result_o !== exp) begin
        n_fail++;
        $display("FAIL backpressure cycle %0d: valid_o=%b ready_o=%b result_o=%h, required 1 0 %h",
                 i, valid_o, ready_o, result_o, exp);
      end
      @(posedge clk_i); #1;
    end
    ready_i = 1'b1;
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    n_checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== exp) begin
      n_fail++;
      $display("FAIL bp_release: ready_o=%b valid_o=%b result_o=%h, required 1 0 %h",
               ready_o, valid_o, result_o, exp);
    end
    repeat (NDIG + 2) @(posedge clk_i);
    #1;
    n_checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== exp) begin
      n_fail++;
      $display("FAIL bp_no_extra: ready_o=%b valid_o=%b result_o=%h, required 1 0 %h",
               ready_o, valid_o, result_o, exp);
    end
  endtask

  task automatic test_mid_reset();
    ready_i = 1'b1;
    min_i   = 16'h8051;
    sub_i   = 16'h8086;
    valid_i = 1'b1;
    sb.push_back(model(16'h8051, 16'h8086));
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    sb.delete();
    #1;
    n_checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 17'h00000) begin
      n_fail++;
      $display("FAIL mid_reset: valid_o=%b ready_o=%b result_o=%h, required 0 1 00000",
               valid_o, ready_o, result_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    do_op(16'h5555, 16'hAAAA);
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp;
    ready_i = 1'b1;
    min_i   = 16'h1024;
    sub_i   = 16'h8192;
    valid_i = 1'b1;
    sb.push_back(model(16'h1024, 16'h8192));
    @(posedge clk_i); #1;
    min_i = 16'h4096;
    sub_i = 16'h2048;
    sb.push_back(model(16'h4096, 16'h2048));
    repeat (NDIG) @(posedge clk_i);
    #1;
    exp = sb.pop_front();
    n_checks++;
    if (valid_o !== 1'b1 || result_o !== exp) begin
      n_fail++;
      $display("FAIL b2b_first: valid_o=%b result_o=%h, required 1 %h", valid_o, result_o, exp);
    end
    @(posedge clk_i); #1;
    n_checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_handshake: ready_o=%b valid_o=%b, required 1 0", ready_o, valid_o);
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    n_checks++;
    if (ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: ready_o=%b, required 0", ready_o);
    end
    repeat (NDIG) @(posedge clk_i);
    #1;
    exp = sb.pop_front();
    n_checks++;
    if (valid_o !== 1'b1 || result_o !== exp) begin
      n_fail++;
      $display("FAIL b2b_second: valid_o=%b result_o=%h, required 1 %h", valid_o, result_o, exp);
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    valid_i  = 1'b0;
    ready_i  = 1'b1;
    min_i    = '0;
    sub_i    = '0;
    rst_ni   = 1'b0;
    test_reset();
    test_basic();
    test_borrow_wrap();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
